// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-port round-robin arbiter in front of one single-port SRAM.
// Grants at most one access per cycle and steers read data back to the port
// that issued each read, after the SRAM's fixed read latency (RD_LATENCY).
// Optional lock support is compiled in with `define MEM_ARB_LOCK_EN; without it
// the p0_lock/p1_lock inputs are ignored.
//
// Lock FSM (MEM_ARB_LOCK_EN only):
//   state    | meaning
//   UNLOCKED | plain round-robin between both ports
//   LOCKED   | only lock_owner may be granted until it issues an access with lock=0
module mem_port_arbiter #(
  parameter int ADDR_BITS  = 10,
  parameter int DATA_WIDTH = 256,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [ADDR_BITS-1:0]  p0_addr,
  input  logic [STRB_WIDTH-1:0] p0_wmask,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  input  logic                  p0_lock,
  output logic                  p0_gnt,
  output logic                  p0_rvalid,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [ADDR_BITS-1:0]  p1_addr,
  input  logic [STRB_WIDTH-1:0] p1_wmask,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  input  logic                  p1_lock,
  output logic                  p1_gnt,
  output logic                  p1_rvalid,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [STRB_WIDTH-1:0] mem_wmask,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  // Index of the last granted port; reset to 1 so port 0 wins the first contention.
  logic rr_last;
  logic elig0, elig1;
  logic gnt0, gnt1;

  // Read-return pipeline: one {valid, port_id} entry per cycle of SRAM latency.
  logic [RD_LATENCY-1:0] pipe_vld;
  logic [RD_LATENCY-1:0] pipe_id;

`ifdef MEM_ARB_LOCK_EN
  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_t;

  lock_state_t lock_state;
  logic        lock_owner;

  // Lock FSM: enter on an accepted access with lock=1, leave when the owner is accepted with lock=0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_state <= UNLOCKED;
      lock_owner <= 1'b0;
    end else begin
      case (lock_state)
        UNLOCKED: begin
          if (gnt0 && p0_lock) begin
            lock_state <= LOCKED;
            lock_owner <= 1'b0;
          end else if (gnt1 && p1_lock) begin
            lock_state <= LOCKED;
            lock_owner <= 1'b1;
          end
        end
        LOCKED: begin
          if (lock_owner ? (gnt1 && !p1_lock) : (gnt0 && !p0_lock))
            lock_state <= UNLOCKED;
        end
      endcase
    end
  end

  // While locked, the non-owner is masked out even if the owner is idle.
  assign elig0 = p0_req & ((lock_state == UNLOCKED) | ~lock_owner);
  assign elig1 = p1_req & ((lock_state == UNLOCKED) |  lock_owner);
`else
  logic unused_lock;
  assign unused_lock = p0_lock ^ p1_lock;
  assign elig0 = p0_req;
  assign elig1 = p1_req;
`endif

  // Round-robin: a lone requester wins; under contention the port not granted last wins.
  assign gnt0 = rst_n & elig0 & (~elig1 |  rr_last);
  assign gnt1 = rst_n & elig1 & (~elig0 | ~rr_last);

  assign p0_gnt = gnt0;
  assign p1_gnt = gnt1;
  assign mem_en = gnt0 | gnt1;

  // SRAM request mux; all fields are zero when nobody is granted.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wmask = '0;
    mem_wdata = '0;
    if (gnt0) begin
      mem_we    = p0_we;
      mem_addr  = p0_addr;
      mem_wmask = p0_wmask;
      mem_wdata = p0_wdata;
    end else if (gnt1) begin
      mem_we    = p1_we;
      mem_addr  = p1_addr;
      mem_wmask = p1_wmask;
      mem_wdata = p1_wdata;
    end
  end

  // Round-robin pointer and read-return pipeline; reset drops in-flight reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_last  <= 1'b1;
      pipe_vld <= '0;
      pipe_id  <= '0;
    end else begin
      if (mem_en)
        rr_last <= gnt1;
      pipe_vld[0] <= mem_en & ~mem_we;
      pipe_id[0]  <= gnt1;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_id[i]  <= pipe_id[i-1];
      end
    end
  end

  // The last stage lines up with mem_rdata; gating with rst_n keeps rvalid low during reset.
  assign p0_rvalid = rst_n & pipe_vld[RD_LATENCY-1] & ~pipe_id[RD_LATENCY-1];
  assign p1_rvalid = rst_n & pipe_vld[RD_LATENCY-1] &  pipe_id[RD_LATENCY-1];
  assign p0_rdata  = mem_rdata;
  assign p1_rdata  = mem_rdata;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port SRAM between two memory requesters, e.g. the write and read sides of the AXI memory slave, or the AXI slave and a DMA/debug port.
- Sits between the requesters' mem ports and the SRAM macro.
- Grants one access per cycle using round-robin priority.
- Routes read data back to the requester that issued the read, after a fixed SRAM read latency.

Parameters:
- ADDR_BITS, 10, SRAM word-address width
- DATA_WIDTH, 256, SRAM data width in bits
- STRB_WIDTH, DATA_WIDTH/8, byte-mask width
- RD_LATENCY, 1, SRAM read latency in cycles from accepted read to valid mem_rdata; legal range 1..4

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low
- p0_req  in  1  port 0 access request
- p0_we  in  1  port 0 write (1) / read (0)
- p0_addr  in  ADDR_BITS  port 0 word address
- p0_wmask  in  STRB_WIDTH  port 0 byte write mask
- p0_wdata  in  DATA_WIDTH  port 0 write data
- p0_lock  in  1  port 0 lock request (only with MEM_ARB_LOCK_EN)
- p0_gnt  out  1  port 0 request accepted this cycle
- p0_rvalid  out  1  port 0 read data valid
- p0_rdata  out  DATA_WIDTH  port 0 read data
- p1_req, p1_we, p1_addr, p1_wmask, p1_wdata, p1_lock, p1_gnt, p1_rvalid, p1_rdata  same directions, widths and meanings as port 0, for port 1
- mem_en  out  1  SRAM access enable
- mem_we  out  1  SRAM write enable
- mem_addr  out  ADDR_BITS  SRAM address
- mem_wmask  out  STRB_WIDTH  SRAM byte mask
- mem_wdata  out  DATA_WIDTH  SRAM write data
- mem_rdata  in  DATA_WIDTH  SRAM read data

Behaviour:
- Handshake:
  - A request is accepted in a cycle where px_req=1 and px_gnt=1.
  - The requester holds req, we, addr, wmask and wdata stable until accepted.
  - Grant is combinational from req and arbiter state, in the same cycle.
  - px_gnt never asserts without px_req.
- Arbitration:
  - Register rr_last (1 bit) holds the index of the last granted port.
  - Only one port requesting: that port is granted.
  - Both requesting: port !rr_last is granted.
  - rr_last updates to the granted index on every accepted request.
  - Reset value of rr_last is 1, so port 0 wins the first contention.
  - Under continuous contention, grants strictly alternate; maximum wait is 1 cycle.
- SRAM side:
  - mem_en = p0_gnt | p1_gnt.
  - mem_we, mem_addr, mem_wmask and mem_wdata are muxed from the granted port.
  - With no grant, mem_we=0 and mem_addr/mem_wmask/mem_wdata=0.
- Read return:
  - Shift pipeline of RD_LATENCY stages, each holding {valid, port_id}.
  - Stage 0 loads valid=mem_en&~mem_we and port_id=granted index.
  - px_rvalid=1 exactly RD_LATENCY cycles after an accepted read by port x, for one cycle.
  - Writes never produce rvalid.
  - p0_rdata and p1_rdata are both driven directly by mem_rdata; data is meaningful only while the matching rvalid is high.
  - p0_rvalid and p1_rvalid are never high in the same cycle.
  - Back-to-back reads from alternating ports return in issue order, one per cycle, with no bubbles.
- Reset, while rst_n=0:
  - p0_gnt, p1_gnt, mem_en, mem_we, p0_rvalid and p1_rvalid are forced to 0.
  - The pipeline is cleared and rr_last=1.
- Reset mid-operation: in-flight reads are dropped; no rvalid appears after reset releases.
- Simultaneous read and write requests: treated identically; the round-robin rule alone decides the grant.

Optional Feature:
- Macro: MEM_ARB_LOCK_EN.
- When defined, a 2-state FSM runs with states UNLOCKED and LOCKED(owner):
  - UNLOCKED → LOCKED(x) when port x is accepted with px_lock=1.
  - In LOCKED(x), only port x may be granted; the other port sees gnt=0 even when x is idle.
  - LOCKED(x) → UNLOCKED when port x is accepted with px_lock=0.
  - rr_last is still updated on every acceptance.
  - Reset returns the FSM to UNLOCKED.
- When not defined: px_lock inputs are ignored, no FSM exists, and pure round-robin applies.

Test Plan:
- Reset: hold rst_n=0 with p0_req=p1_req=1 → p0_gnt=p1_gnt=mem_en=0 and no rvalid. Release reset → p0 is granted in the first cycle.
- Contention: p0 and p1 both read continuously, p0_addr=0x010, p1_addr=0x020, RD_LATENCY=1 → mem_addr alternates 0x010,0x020,0x010,… Each px_rvalid follows 1 cycle after its grant, with rdata matching preloaded words.
- Write then read: p1 writes 0xA5A5… to 0x3FF with wmask all-ones, then p0 reads 0x3FF → p0_rvalid after RD_LATENCY cycles with rdata=0xA5A5…, and p1_rvalid never asserts.
- Latency: RD_LATENCY=3, p0 reads 0x005 at cycle t → p0_rvalid only at t+3. Reset asserted at t+1 → no rvalid at t+3.
- Lock (MEM_ARB_LOCK_EN): p0 issues 4 writes with p0_lock=1,1,1,0 while p1_req is held high → p1_gnt=0 until the 4th p0 acceptance, then p1 is granted next cycle.
- Single requester: only p1 requests for 8 cycles → p1_gnt=1 every cycle and rr_last=1 throughout.
